// File: rtl/psum_acc_bank.sv
// Partial-sum accumulation bank. Each entry holds `col` signed lanes.
// WS mode accumulates into an addressed entry; OS mode captures beats
// into consecutive entries. A drain streams entries out, clearing each
// entry as it is read so the bank is ready for the next tile.
module psum_acc_bank #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 16,
    parameter int addr_w  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [psum_bw*col-1:0] in_data,
    input  logic [addr_w-1:0]      in_addr,
    input  logic                   in_first,
    input  logic                   drain_start,
    input  logic [addr_w:0]        drain_len,
    input  logic                   relu_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [psum_bw*col-1:0] out_data,
    output logic                   out_last,
    output logic                   overflow
);

    // state | meaning
    // IDLE  | no capture in progress; next accepted beat latches mode
    // ACC   | accumulating / capturing with the latched mode
    // DRAIN | streaming entries 0..drain_len-1 out, clearing each
    typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;

    localparam logic [addr_w:0]    depth_c = (addr_w + 1)'(depth);
    localparam logic [addr_w:0]    len_one = (addr_w + 1)'(1);
    localparam logic [addr_w-1:0]  ptr_one = addr_w'(1);
    localparam logic [addr_w-1:0]  last_c  = addr_w'(depth - 1);
    localparam logic [psum_bw-1:0] max_c   = {1'b0, {(psum_bw - 1){1'b1}}};
    localparam logic [psum_bw-1:0] min_c   = {1'b1, {(psum_bw - 1){1'b0}}};

    state_t                 state, state_nx;
    logic [psum_bw*col-1:0] entry [depth];
    logic [addr_w-1:0]      wr_ptr, rd_ptr;
    logic [addr_w:0]        len_q;
    logic                   relu_q, mode_q, mode_eff;
    logic                   in_fire, out_fire, drain_ok, addr_ok, rd_last;
    logic [psum_bw*col-1:0] acc_val;

    // Signed add clamped to the lane range instead of wrapping.
    function automatic logic [psum_bw-1:0] sat_add(input logic [psum_bw-1:0] a,
                                                   input logic [psum_bw-1:0] b);
        logic signed [psum_bw:0] s;
        s = $signed({a[psum_bw-1], a}) + $signed({b[psum_bw-1], b});
        if (s[psum_bw] != s[psum_bw-1])
            sat_add = s[psum_bw] ? min_c : max_c;
        else
            sat_add = s[psum_bw-1:0];
    endfunction

    // Handshake and decode terms; the beat in IDLE uses the live mode since it is the one being latched.
    always_comb begin
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        drain_ok = drain_start && (state != DRAIN) && (drain_len != '0) && (drain_len <= depth_c);
        addr_ok  = ({1'b0, in_addr} < depth_c);
        rd_last  = ({1'b0, rd_ptr} == (len_q - len_one));
        mode_eff = (state == IDLE) ? mode : mode_q;
    end

    // Per-lane saturating sum of the addressed entry and the incoming beat.
    always_comb begin
        acc_val = '0;
        for (int i = 0; i < col; i++)
            acc_val[psum_bw*i +: psum_bw] = sat_add(entry[in_addr][psum_bw*i +: psum_bw],
                                                    in_data[psum_bw*i +: psum_bw]);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; a drain request wins over staying in capture.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (drain_ok)     state_nx = DRAIN;
                else if (in_fire) state_nx = ACC;
            end
            ACC:   if (drain_ok) state_nx = DRAIN;
            DRAIN: if (out_fire && rd_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode; readout lanes optionally clamped at zero.
    always_comb begin
        in_ready  = (state != DRAIN);
        out_valid = (state == DRAIN);
        out_last  = (state == DRAIN) && rd_last;
        out_data  = '0;
        if (state == DRAIN) begin
            for (int i = 0; i < col; i++)
                out_data[psum_bw*i +: psum_bw] =
                    (relu_q && entry[rd_ptr][psum_bw*(i+1)-1]) ? '0 : entry[rd_ptr][psum_bw*i +: psum_bw];
        end
    end

    // Pointers, latched drain parameters, mode and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q   <= 1'b0;
            len_q    <= '0;
            relu_q   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (in_fire && state == IDLE) mode_q <= mode;
            if (in_fire) begin
                if (mode_eff) begin
                    wr_ptr <= (wr_ptr == last_c) ? '0 : wr_ptr + ptr_one;
                    if (wr_ptr == last_c) overflow <= 1'b1;
                end else if (!addr_ok) begin
                    overflow <= 1'b1;
                end
            end
            if (drain_ok) begin
                len_q  <= drain_len;
                relu_q <= relu_en;
                rd_ptr <= '0;
            end
            if (out_fire) begin
                if (rd_last) begin
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                end else begin
                    rd_ptr <= rd_ptr + ptr_one;
                end
            end
        end
    end

    // Entry storage: capture/accumulate on input beats, clear-on-read during drain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int e = 0; e < depth; e++) entry[e] <= '0;
        end else if (in_fire) begin
            if (mode_eff)     entry[wr_ptr]  <= in_data;
            else if (addr_ok) entry[in_addr] <= in_first ? in_data : acc_val;
        end else if (out_fire) begin
            entry[rd_ptr] <= '0;
        end
    end

endmodule

// File: tb/tb_psum_acc_bank.sv
// Bench for psum_acc_bank: a plain-integer array model produces expected
// readout beats into a queue; a negedge monitor pops and compares them.
module tb_psum_acc_bank;
    localparam int COL = 8, BW = 16, DEPTH = 16, AW = 4, W = COL * BW;

    logic           clk = 1'b0, rst_n;
    logic           mode, in_valid, in_ready, in_first, drain_start, relu_en;
    logic           out_valid, out_ready, out_last, overflow;
    logic [W-1:0]   in_data, out_data;
    logic [AW-1:0]  in_addr;
    logic [AW:0]    drain_len;

    psum_acc_bank #(.col(COL), .psum_bw(BW), .depth(DEPTH), .addr_w(AW)) dut (
        .clk(clk), .reset(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_addr(in_addr), .in_first(in_first),
        .drain_start(drain_start), .drain_len(drain_len), .relu_en(relu_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct { logic [W-1:0] data; logic last; } exp_t;
    exp_t exp_q[$];
    int checks = 0, passed = 0;

    int m [DEPTH][COL];
    int m_wr;
    bit m_idle, m_mode, m_ovf;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic logic [W-1:0] pack_row(input int r, input bit relu);
        logic [W-1:0] v;
        int x;
        v = '0;
        for (int l = 0; l < COL; l++) begin
            x = m[r][l];
            if (relu && x < 0) x = 0;
            v[BW*l +: BW] = BW'(x);
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < DEPTH; r++)
            for (int l = 0; l < COL; l++) m[r][l] = 0;
        m_wr = 0; m_idle = 1; m_mode = 0; m_ovf = 0;
    endtask

    // Drive one beat (not clocked) and apply it to the model.
    task automatic set_beat(input bit md, input int addr, input bit first, input int d[COL]);
        logic [W-1:0] v;
        bit eff;
        v = '0;
        for (int l = 0; l < COL; l++) v[BW*l +: BW] = BW'(d[l]);
        mode = md; in_addr = AW'(addr); in_first = first; in_data = v; in_valid = 1'b1;
        eff = m_idle ? md : m_mode;
        if (m_idle) begin m_mode = md; m_idle = 0; end
        if (eff) begin
            for (int l = 0; l < COL; l++) m[m_wr][l] = d[l];
            m_wr++;
            if (m_wr == DEPTH) begin m_wr = 0; m_ovf = 1; end
        end else if (addr >= DEPTH) begin
            m_ovf = 1;
        end else begin
            for (int l = 0; l < COL; l++) m[addr][l] = first ? d[l] : sat(m[addr][l] + d[l]);
        end
    endtask

    task automatic beat(input bit md, input int addr, input bit first, input int d[COL]);
        set_beat(md, addr, first, d);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic beat_all(input bit md, input int addr, input bit first, input int val);
        int d[COL];
        for (int l = 0; l < COL; l++) d[l] = val;
        beat(md, addr, first, d);
    endtask

    // Issue a drain (possibly alongside a pending beat) and run it to completion.
    task automatic drain(input int len, input bit relu, input int stall_at);
        int n;
        logic [W-1:0] hold_d;
        logic hold_l;
        for (int k = 0; k < len; k++) exp_q.push_back('{pack_row(k, relu), (k == len - 1)});
        for (int k = 0; k < len; k++)
            for (int l = 0; l < COL; l++) m[k][l] = 0;
        m_idle = 1; m_wr = 0;
        drain_start = 1'b1; drain_len = (AW + 1)'(len); relu_en = relu;
        @(posedge clk); #1;
        drain_start = 1'b0; in_valid = 1'b0;
        check("drain_latency", out_valid, 1'b1);
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            if (n == stall_at) begin
                out_ready = 1'b0;
                hold_d = out_data; hold_l = out_last;
                repeat (3) begin
                    @(posedge clk); #1;
                    check("stall_data", out_data, hold_d);
                    check("stall_last", out_last, hold_l);
                    check("stall_valid", out_valid, 1'b1);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            n++;
        end
        check("drain_complete", exp_q.size(), 0);
        exp_q.delete();
        out_ready = 1'b1;
        check("drain_end_valid", out_valid, 1'b0);
        check("drain_end_ready", in_ready, 1'b1);
    endtask

    // Monitor: compare each accepted readout beat with the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", out_data, e.data);
                check("beat_last", out_last, e.last);
            end
        end
    end

    initial begin
        int d[COL];
        int nb, len;
        bit md, with_drain;

        rst_n = 1'b0; mode = 0; in_valid = 0; in_first = 0; in_addr = '0; in_data = '0;
        drain_start = 0; drain_len = '0; relu_en = 0; out_ready = 1'b1;
        model_reset();
        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // Fresh bank drains all zeros.
        drain(16, 0, -1);
        check("overflow_after_zero_drain", overflow, m_ovf);

        // WS accumulate at entry 3.
        beat_all(0, 3, 1, 100);
        beat_all(0, 3, 0, 100);
        beat_all(0, 3, 0, 100);
        drain(4, 0, -1);

        // Saturation at both ends.
        beat_all(0, 0, 1, 32000);
        beat_all(0, 0, 0, 1000);
        beat_all(0, 1, 1, -32000);
        beat_all(0, 1, 0, -1000);
        drain(2, 0, -1);

        // ReLU on and off.
        for (int l = 0; l < COL; l++) d[l] = (l % 2) ? -5 : 7;
        beat(0, 0, 1, d);
        drain(1, 1, -1);
        beat(0, 0, 1, d);
        drain(1, 0, -1);

        // Out-of-range drain lengths are ignored.
        drain_start = 1'b1; drain_len = '0;
        @(posedge clk); #1;
        drain_len = 5'd17;
        @(posedge clk); #1;
        drain_start = 1'b0;
        check("bad_len_valid", out_valid, 1'b0);
        check("bad_len_ready", in_ready, 1'b1);

        // OS capture of 17 beats wraps; later mode/addr/first inputs are ignored.
        for (int k = 0; k <= 16; k++) begin
            for (int l = 0; l < COL; l++) d[l] = k;
            beat((k == 0) ? 1'b1 : 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                 1'($urandom_range(0, 1)), d);
        end
        check("os_overflow", overflow, m_ovf);
        drain(16, 0, -1);
        check("overflow_sticky", overflow, m_ovf);

        // Randomized rounds, sometimes with the final beat coincident with drain_start.
        for (int r = 0; r < 8; r++) begin
            md = 1'($urandom_range(0, 1));
            nb = $urandom_range(1, 20);
            with_drain = 1'($urandom_range(0, 1));
            for (int b = 0; b < nb; b++) begin
                for (int l = 0; l < COL; l++)
                    d[l] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 65535)) - 32768
                                                       : int'($urandom_range(0, 400)) - 200;
                if (b == nb - 1 && with_drain)
                    set_beat(md, $urandom_range(0, 15), 1'($urandom_range(0, 1)), d);
                else
                    beat(md, $urandom_range(0, 15), 1'($urandom_range(0, 1)), d);
            end
            len = $urandom_range(1, 16);
            drain(len, 1'($urandom_range(0, 1)), (r == 3) ? 4 : -1);
            check("overflow_round", overflow, m_ovf);
        end

        // Explicit stall mid-drain with known data.
        for (int a = 0; a < 16; a++) beat_all(0, a, 1, a * 10 - 70);
        drain(16, 0, 5);

        // Reset in the middle of a drain.
        for (int a = 0; a < 8; a++) beat_all(0, a, 1, a + 1);
        for (int k = 0; k < 16; k++) exp_q.push_back('{pack_row(k, 0), (k == 15)});
        drain_start = 1'b1; drain_len = 5'd16; relu_en = 0; out_ready = 1'b1;
        @(posedge clk); #1;
        drain_start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_data", out_data, '0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_overflow", overflow, 1'b0);
        exp_q.delete();
        model_reset();
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_rst_idle", out_valid, 1'b0);
        end
        drain(16, 0, -1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/psum_acc_bank.md
PSUM_ACC_BANK -- requirements
Module: psum_acc_bank

Interface
REQ-001 Parameters SHALL be, one per line:
- col, 8, number of psum lanes
- psum_bw, 16, signed psum width per lane
- depth, 16, number of accumulation entries
- addr_w, 4, entry address width, ceil(log2(depth))
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- mode  in  1  0 = WS (addressed accumulate), 1 = OS (sequential capture)
- in_valid  in  1  input beat offered
- in_ready  out  1  bank accepts input beat
- in_data  in  psum_bw*col  lane i at bits [psum_bw*(i+1)-1 : psum_bw*i]
- in_addr  in  addr_w  WS target entry
- in_first  in  1  WS: overwrite entry instead of accumulating
- drain_start  in  1  pulse; begin readout
- drain_len  in  addr_w+1  number of entries to drain, 1..depth
- relu_en  in  1  apply ReLU on readout
- out_valid  out  1  readout beat valid
- out_ready  in  1  downstream accepts readout beat
- out_data  out  psum_bw*col  readout entry, same lane packing
- out_last  out  1  final beat of drain
- overflow  out  1  sticky: OS wrap or WS out-of-range address

Function
REQ-003 The FSM SHALL have states IDLE, ACC, DRAIN; in_ready = 1 in IDLE/ACC, 0 in DRAIN.
REQ-004 Transfers SHALL occur only on cycles where valid and ready are both 1.
REQ-005 mode SHALL be latched on any accepted beat in IDLE (IDLE->ACC); mode changes in ACC/DRAIN SHALL be ignored.
REQ-006 WS beat SHALL write entry[in_addr] = in_data if in_first, else entry + in_data, per lane.
REQ-007 Accumulation SHALL be signed and saturating per lane to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
REQ-008 WS beat with in_addr >= depth SHALL be accepted, SHALL NOT alter storage, and SHALL set overflow.
REQ-009 OS beat SHALL overwrite entry[wr_ptr] and increment wr_ptr; wr_ptr wrapping depth-1 -> 0 SHALL set overflow; in_addr and in_first SHALL be ignored.
REQ-010 drain_start in IDLE/ACC with drain_len in 1..depth SHALL enter DRAIN next cycle, latching drain_len and relu_en and setting rd_ptr = 0; drain_len = 0 or > depth SHALL be ignored.
REQ-011 A beat accepted in the same cycle as drain_start SHALL be written first; the drain SHALL observe the updated value.
REQ-012 In DRAIN:
- out_valid = 1
- out_data = entry[rd_ptr], with each negative lane forced to 0 when the latched relu_en = 1
- out_last = 1 when rd_ptr = drain_len-1
REQ-013 On an accepted readout beat, entry[rd_ptr] SHALL be cleared to 0 and rd_ptr SHALL increment; the last beat SHALL return the FSM to IDLE and reset wr_ptr to 0.
REQ-014 While out_ready = 0, out_data, out_last and rd_ptr SHALL hold stable.
REQ-015 First readout beat SHALL be valid one cycle after drain_start; throughput SHALL be one beat per cycle in both directions.
REQ-016 overflow SHALL remain set until reset; it SHALL NOT block operation.

Reset
REQ-017 reset = 0 SHALL immediately force:
- state IDLE, wr_ptr = 0, rd_ptr = 0
- all entries = 0
- out_valid = 0, out_last = 0, out_data = 0, overflow = 0
- in_ready = 1
REQ-018 Reset asserted mid-drain or mid-accumulate SHALL abort the operation, with no further out_valid until a new drain_start.

Verification
REQ-019 The bench SHALL cover, with col=8, psum_bw=16, depth=16:
- Reset, then drain_len=16 -> 16 beats, all lanes 0, out_last on beat 16, overflow=0.
- WS: addr 3, in_first=1 data 100, then two beats of 100; drain_len=4 -> entries 0-2 = 0, entry 3 all lanes 300, out_last on 4th.
- Saturation: 32000 then +1000 -> 32767; -32000 then -1000 -> -32768.
- ReLU: lane value -5 -> out 0 with relu_en=1; 0xFFFB with relu_en=0.
- OS: 17 beats, lanes = k (k = 0..16) -> overflow=1, entry 0 = 16, entry 1 = 1; drain_len=16 -> 16,1,2..15.
- out_ready low 3 cycles mid-drain -> outputs stable; reset mid-drain -> out_valid=0 immediately, re-drain returns zeros.
